// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply (radix-2 Booth) / divide (restoring) unit.
// Produces the low product word or the truncated quotient 33 cycles after start.
module multdiv_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        data_busy
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 6;
  localparam logic [W-1:0]  INT_MIN  = {1'b1, {(W-1){1'b0}}};
  localparam logic [CW-1:0] LAST_IT  = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          is_div_q, is_div_d;
  logic          neg_q, neg_d;
  logic          divz_q, divz_d;
  logic          ovf_q, ovf_d;
  logic [W:0]    acc_q, acc_d;
  logic [W-1:0]  qr_q, qr_d;
  logic          qm1_q, qm1_d;
  logic [W:0]    m_q, m_d;
  logic [W-1:0]  result_q, result_d;
  logic          exc_q, exc_d;
  logic          rdy_q, rdy_d;
  logic          busy_q, busy_d;

  logic [W:0]    booth_sum;
  logic [W:0]    div_shift;
  logic [W:0]    div_trial;
  logic [W:0]    prod_hi;
  logic [W-1:0]  a_mag, b_mag;
  logic [W-1:0]  fin_result;
  logic          fin_exc;

  // Datapath helpers: one Booth step, one restoring step, and final fix-up
  always_comb begin
    a_mag = data_operandA[W-1] ? (~data_operandA + 32'd1) : data_operandA;
    b_mag = data_operandB[W-1] ? (~data_operandB + 32'd1) : data_operandB;

    unique case ({qr_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + m_q;
      2'b10:   booth_sum = acc_q - m_q;
      default: booth_sum = acc_q;
    endcase

    div_shift = {acc_q[W-1:0], qr_q[W-1]};
    div_trial = div_shift - m_q;

    // Product bits [63:31] must all match for the low word to be exact
    prod_hi = {acc_q[W-1:0], qr_q[W-1]};

    fin_result = qr_q;
    fin_exc    = 1'b0;
    if (!is_div_q) begin
      fin_exc = !((prod_hi == '0) || (prod_hi == '1));
    end else if (divz_q) begin
      fin_result = '0;
      fin_exc    = 1'b1;
    end else if (ovf_q) begin
      fin_result = INT_MIN;
      fin_exc    = 1'b1;
    end else if (neg_q) begin
      fin_result = ~qr_q + 32'd1;
    end
  end

  // Next-state and register-input logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    divz_d   = divz_q;
    ovf_d    = ovf_q;
    acc_d    = acc_q;
    qr_d     = qr_q;
    qm1_d    = qm1_q;
    m_d      = m_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    busy_d   = busy_q;

    unique case (state_q)
      IDLE: begin
        if (ctrl_MULT || ctrl_DIV) begin
          state_d  = RUN;
          busy_d   = 1'b1;
          cnt_d    = '0;
          is_div_d = !ctrl_MULT;
          neg_d    = data_operandA[W-1] ^ data_operandB[W-1];
          divz_d   = (data_operandB == '0);
          ovf_d    = (data_operandA == INT_MIN) && (data_operandB == '1);
          acc_d    = '0;
          qm1_d    = 1'b0;
          if (ctrl_MULT) begin
            qr_d = data_operandB;
            m_d  = {data_operandA[W-1], data_operandA};
          end else begin
            qr_d = a_mag;
            m_d  = {1'b0, b_mag};
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q + 6'd1;
        if (!is_div_q) begin
          acc_d = {booth_sum[W], booth_sum[W:1]};
          qr_d  = {booth_sum[0], qr_q[W-1:1]};
          qm1_d = qr_q[0];
        end else if (div_trial[W]) begin
          acc_d = div_shift;
          qr_d  = {qr_q[W-2:0], 1'b0};
        end else begin
          acc_d = div_trial;
          qr_d  = {qr_q[W-2:0], 1'b1};
        end
        if (cnt_q == LAST_IT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        result_d = fin_result;
        exc_d    = fin_exc;
        rdy_d    = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      divz_q   <= 1'b0;
      ovf_q    <= 1'b0;
      acc_q    <= '0;
      qr_q     <= '0;
      qm1_q    <= 1'b0;
      m_q      <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      divz_q   <= divz_d;
      ovf_q    <= ovf_d;
      acc_q    <= acc_d;
      qr_q     <= qr_d;
      qm1_q    <= qm1_d;
      m_q      <= m_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign data_busy      = busy_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: directed corner cases plus random ops
// checked against a plain-arithmetic reference model.
module tb_multdiv_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        data_busy;

  multdiv_unit dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .data_busy      (data_busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          rdy_edge;
    string       name;
  } exp_t;

  exp_t sb[$];

  function automatic void model(input logic is_mult, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] r,
                                output logic e);
    longint p;
    if (is_mult) begin
      p = longint'($signed(a)) * longint'($signed(b));
      r = p[31:0];
      e = (p != longint'($signed(r)));
    end else if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      p = longint'($signed(a)) / longint'($signed(b));
      r = p[31:0];
      e = 1'b0;
    end
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pops one expectation for every RDY pulse the DUT presents
  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_rdy: got RDY at edge %0d expected none", cyc);
        end else begin
          e = sb.pop_front();
          check({e.name, "_result"}, 64'(data_result), 64'(e.res));
          check({e.name, "_exc"}, 64'(data_exception), 64'(e.exc));
          check({e.name, "_latency"}, 64'(cyc), 64'(e.rdy_edge));
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Called at a negedge; the following posedge is the start edge
  task automatic start_op(input logic mult, input logic div, input logic [31:0] a,
                          input logic [31:0] b, input string name);
    logic [31:0] r;
    logic        e;
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = mult;
    ctrl_DIV      = div;
    model(mult, a, b, r, e);
    sb.push_back('{r, e, cyc + 1 + 33, name});
    @(negedge clock);
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
  endtask

  // Returns at the negedge where RDY is seen; busy must be high until then
  task automatic wait_rdy(input string name, input bit hold_div);
    int busy_bad = 0;
    bit seen     = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (data_resultRDY === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (data_busy !== 1'b1) busy_bad++;
        data_operandA = $urandom;
        data_operandB = $urandom;
        ctrl_DIV      = hold_div;
        @(negedge clock);
      end
    end
    ctrl_DIV = 1'b0;
    check({name, "_busy_run"}, 64'(busy_bad), 64'd0);
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no RDY within 40 cycles expected RDY", name);
    end else begin
      check({name, "_busy_drop"}, 64'(data_busy), 64'd0);
    end
  endtask

  task automatic run_op(input logic mult, input logic div, input logic [31:0] a,
                        input logic [31:0] b, input string name);
    start_op(mult, div, a, b, name);
    wait_rdy(name, 1'b0);
  endtask

  function automatic logic [31:0] pick_operand();
    unique case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 100));
      4:       return -32'($urandom_range(1, 100));
      5:       return 32'($urandom_range(0, 65535)) << $urandom_range(0, 16);
      default: return $urandom;
    endcase
  endfunction

  task automatic check_reset_outputs(input string name);
    check({name, "_result"}, 64'(data_result), 64'd0);
    check({name, "_exc"}, 64'(data_exception), 64'd0);
    check({name, "_rdy"}, 64'(data_resultRDY), 64'd0);
    check({name, "_busy"}, 64'(data_busy), 64'd0);
  endtask

  initial begin
    fork
      monitor_loop();
    join_none

    reset         = 1'b1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    idle(3);
    check_reset_outputs("reset");
    reset = 1'b0;
    idle(2);

    run_op(1, 0, 32'd7, 32'hFFFF_FFFD, "mul_7_m3");
    idle(1);
    run_op(1, 0, 32'h0001_0000, 32'h0001_0000, "mul_ovf");
    idle(1);
    run_op(1, 0, 32'h8000_0000, 32'd1, "mul_min_1");
    idle(1);
    run_op(1, 0, 32'h8000_0000, 32'h8000_0000, "mul_min_min");
    idle(1);
    run_op(0, 1, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    idle(1);
    run_op(0, 1, 32'd100, 32'd0, "div_by_zero");
    idle(1);
    run_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
    idle(1);

    // Start held high with operands toggling must not restart the op
    start_op(0, 1, 32'd1000, 32'hFFFF_FFF9, "div_hold");
    wait_rdy("div_hold", 1'b1);
    idle(40);

    run_op(1, 1, 32'd6, 32'd3, "both_start");
    // Next start issued in the RDY cycle
    run_op(0, 1, 32'd12345, 32'd17, "b2b_div");
    run_op(1, 0, 32'hFFFF_0000, 32'd3, "b2b_mul");
    idle(2);

    // Abort mid-run: no RDY may follow
    start_op(1, 0, 32'd123, 32'd456, "aborted");
    idle(10);
    reset = 1'b1;
    void'(sb.pop_back());
    @(negedge clock);
    reset = 1'b0;
    check_reset_outputs("abort");
    idle(40);
    run_op(1, 0, 32'd5, 32'd5, "mul_5_5");

    for (int i = 0; i < 24; i++) begin
      logic is_mult;
      is_mult = 1'($urandom_range(0, 1));
      start_op(is_mult, !is_mult, pick_operand(), pick_operand(),
               is_mult ? "rnd_mul" : "rnd_div");
      wait_rdy(is_mult ? "rnd_mul" : "rnd_div", 1'b0);
      idle($urandom_range(0, 2));
    end

    idle(5);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
